// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared encodings for the memory-access / MEM-WB stage.
//   MemSize codes, FSM state encoding, byte-enable constants, the
//   store byte-enable helper and the write-back register payload.
package mem_wb_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned RW_W   = 5;
  localparam int unsigned BE_W   = 4;

  // MemSize encodings; 2'b11 decodes as a word access.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [BE_W-1:0] BE_NONE    = 4'b0000;
  localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

  // Everything the write-back mux consumes.
  typedef struct packed {
    logic [WORD_W-1:0] alu_ans;
    logic [WORD_W-1:0] mem_data;
    logic [WORD_W-1:0] pc_addr;
    logic [RW_W-1:0]   rw;
    logic              mem_to_reg;
    logic              rtype_l;
    logic              jal;
    logic              reg_wr;
    logic              valid;
  } wb_reg_t;

  // Byte enables for an access of the given size at the given low address bits.
  function automatic logic [BE_W-1:0] store_be(input logic [1:0] size,
                                               input logic [1:0] addr);
    case (size)
      SZ_BYTE: store_be = BE_W'(BE_BYTE0 << addr);
      SZ_HALF: store_be = addr[1] ? BE_HALF_HI : BE_HALF_LO;
      default: store_be = BE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: selects the addressed byte/half lane of a read word and
// sign- or zero-extends it to 32 bits. Purely combinational.
//   i_rdata  32  read word from the data bus
//   i_addr    2  low byte-address bits
//   i_size    2  MemSize code (00 byte, 01 half, 1x word)
//   i_sign    1  sign-extend when 1
//   o_data   32  extended load data
module load_align
  import mem_wb_pkg::*;
(
  input  logic [WORD_W-1:0] i_rdata,
  input  logic [1:0]        i_addr,
  input  logic [1:0]        i_size,
  input  logic              i_sign,
  output logic [WORD_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection; a half access only looks at addr[1].
  always_comb begin
    w_byte = 8'h00;
    case (i_addr)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Extension to the full word.
  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_sign & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_sign & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage plus MEM/WB pipeline register.
//   Runs a req/ack data-bus transaction for loads/stores, steers store
//   lanes, formats load data, stalls upstream while the bus is busy and
//   registers all write-back inputs.
// Ports:
//   clk, rst                 clock, async active-high reset
//   *_Mem                    Mem-stage instruction fields
//   dm_req/we/addr/wdata/be  data-bus request side (combinational)
//   dm_ack, dm_rdata         data-bus response
//   Mem_Stall                combinational upstream freeze
//   *_Wr                     registered write-back fields
// Optional: MEM_MISALIGN_TRAP_EN adds Misalign_Wr and suppresses
//   misaligned half/word accesses instead of truncating the address.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Valid_Mem,
  input  logic [DATA_W-1:0]     ALU_ans_Mem,
  input  logic [DATA_W-1:0]     Store_Data_Mem,
  input  logic [DATA_W-1:0]     PC_Addr_Mem,
  input  logic                  MemRead_Mem,
  input  logic                  MemWrite_Mem,
  input  logic [1:0]            MemSize_Mem,
  input  logic                  MemSign_Mem,
  input  logic                  MemToReg_Mem,
  input  logic                  Rtype_L_Mem,
  input  logic                  Jal_Mem,
  input  logic                  RegWr_Mem,
  input  logic [REG_ADDR_W-1:0] Rw_Mem,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [DATA_W-1:0]     dm_addr,
  output logic [DATA_W-1:0]     dm_wdata,
  output logic [3:0]            dm_be,
  input  logic                  dm_ack,
  input  logic [DATA_W-1:0]     dm_rdata,
  output logic                  Mem_Stall,
  output logic [DATA_W-1:0]     ALU_ans_Wr,
  output logic [DATA_W-1:0]     Mem_Data_Wr,
  output logic [DATA_W-1:0]     PC_Addr_Wr,
  output logic                  MemToReg_Wr,
  output logic                  Rtype_L_Wr,
  output logic                  Jal_Wr,
  output logic                  RegWr_Wr,
  output logic                  Valid_Wr,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                  Misalign_Wr,
`endif
  output logic [REG_ADDR_W-1:0] Rw_Wr
);

  state_t            r_state;
  state_t            w_state_nxt;
  wb_reg_t           r_wb;
  logic              w_access;
  logic              w_misalign;
  logic              w_pending;
  logic              w_done;
  logic [DATA_W-1:0] w_load_data;

  assign w_access = Valid_Mem & (MemRead_Mem | MemWrite_Mem);

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;
  // MemSize[1] covers both word encodings (10 and 11).
  assign w_misalign = w_access &
                      (((MemSize_Mem == SZ_HALF) & ALU_ans_Mem[0]) |
                       (MemSize_Mem[1] & (ALU_ans_Mem[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_pending = w_access & ~w_misalign;
  assign w_done    = w_pending & dm_ack;
  assign Mem_Stall = w_pending & ~dm_ack;

  // Bus request side, steered from the held Mem-stage fields.
  assign dm_we   = MemWrite_Mem;
  assign dm_addr = {ALU_ans_Mem[DATA_W-1:2], 2'b00};
  assign dm_be   = store_be(MemSize_Mem, ALU_ans_Mem[1:0]);

  always_comb begin
    dm_wdata = Store_Data_Mem;
    case (MemSize_Mem)
      SZ_BYTE: dm_wdata = {4{Store_Data_Mem[7:0]}};
      SZ_HALF: dm_wdata = {2{Store_Data_Mem[15:0]}};
      default: dm_wdata = Store_Data_Mem;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; a zero-wait ack never leaves IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pending && !dm_ack) w_state_nxt = ST_WAIT;
      ST_WAIT: if (dm_ack || !w_pending) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; reset kills the request immediately, not at the next edge.
  always_comb begin
    dm_req = 1'b0;
    case (r_state)
      ST_IDLE: dm_req = w_pending;
      ST_WAIT: dm_req = 1'b1;
      default: dm_req = 1'b0;
    endcase
    if (rst) dm_req = 1'b0;
  end

  load_align u_load_align (
    .i_rdata (dm_rdata),
    .i_addr  (ALU_ans_Mem[1:0]),
    .i_size  (MemSize_Mem),
    .i_sign  (MemSign_Mem),
    .o_data  (w_load_data)
  );

  // MEM/WB register: bubble while stalled, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb <= '0;
    end else if (Mem_Stall) begin
      r_wb.valid      <= 1'b0;
      r_wb.reg_wr     <= 1'b0;
      r_wb.mem_to_reg <= 1'b0;
      r_wb.jal        <= 1'b0;
      r_wb.rtype_l    <= 1'b0;
    end else begin
      r_wb.alu_ans    <= ALU_ans_Mem;
      r_wb.pc_addr    <= PC_Addr_Mem;
      r_wb.rw         <= Rw_Mem;
      r_wb.mem_to_reg <= MemToReg_Mem;
      r_wb.rtype_l    <= Rtype_L_Mem;
      r_wb.jal        <= Jal_Mem;
      r_wb.valid      <= Valid_Mem;
      r_wb.reg_wr     <= RegWr_Mem & Valid_Mem & ~w_misalign;
      if (w_done && MemRead_Mem) r_wb.mem_data <= w_load_data;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // A misaligned access never stalls, so this is set for a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_misalign <= 1'b0;
    else if (Mem_Stall) r_misalign <= 1'b0;
    else                r_misalign <= w_misalign;
  end
  assign Misalign_Wr = r_misalign;
`endif

  assign ALU_ans_Wr  = r_wb.alu_ans;
  assign Mem_Data_Wr = r_wb.mem_data;
  assign PC_Addr_Wr  = r_wb.pc_addr;
  assign Rw_Wr       = r_wb.rw;
  assign MemToReg_Wr = r_wb.mem_to_reg;
  assign Rtype_L_Wr  = r_wb.rtype_l;
  assign Jal_Wr      = r_wb.jal;
  assign RegWr_Wr    = r_wb.reg_wr;
  assign Valid_Wr    = r_wb.valid;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus the MEM/WB pipeline register of the 5-stage pipelined CPU.
- Takes the Mem-stage instruction and runs a req/ack transaction on the data-memory bus for loads and stores.
- Performs byte/half lane steering with sign or zero extension, stalls the pipeline while the bus is busy, and registers everything the write-back mux consumes.
- Outputs feed the write-back unit directly: ALU_ans_Wr, Mem_Data_Wr, PC_Addr_Wr, MemToReg_Wr, Rtype_L_Wr, Jal_Wr, plus register-file write controls.

Parameters:
- DATA_W, 32, datapath and bus width; only 32 is supported.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Valid_Mem  in  1  Mem-stage slot holds a real instruction.
- ALU_ans_Mem  in  32  ALU result; the memory byte address for loads/stores.
- Store_Data_Mem  in  32  rt value to store.
- PC_Addr_Mem  in  32  instruction PC.
- MemRead_Mem, MemWrite_Mem  in  1 each  access type; never both set.
- MemSize_Mem  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- MemSign_Mem  in  1  sign-extend load data when 1.
- MemToReg_Mem, Rtype_L_Mem, Jal_Mem, RegWr_Mem  in  1 each  write-back controls.
- Rw_Mem  in  5  destination register.
- dm_req  out  1  bus request.
- dm_we  out  1  write strobe.
- dm_addr  out  32  word-aligned address {ALU_ans_Mem[31:2],2'b00}.
- dm_wdata  out  32  lane-replicated store data.
- dm_be  out  4  byte enables.
- dm_ack  in  1  transaction complete; dm_rdata is valid in the same cycle.
- dm_rdata  in  32  read word.
- Mem_Stall  out  1  freezes PC/IF/ID/EX/Mem registers.
- ALU_ans_Wr, Mem_Data_Wr, PC_Addr_Wr  out  32 each  registered write-back data.
- MemToReg_Wr, Rtype_L_Wr, Jal_Wr, RegWr_Wr, Valid_Wr  out  1 each  registered write-back controls.
- Rw_Wr  out  5  registered destination register.

Behaviour:
- Reset: all *_Wr outputs are 0, FSM enters IDLE, dm_req=0. Reset mid-transaction abandons it: dm_req drops asynchronously and a later dm_ack is ignored.
- pending = Valid_Mem & (MemRead_Mem | MemWrite_Mem).
- FSM, two states:
  - IDLE: if pending, dm_req=1. dm_ack in the same cycle completes the access (zero-wait) and the FSM stays IDLE; otherwise go to WAIT.
  - WAIT: dm_req=1. On dm_ack, complete and return to IDLE.
- Mem_Stall = pending & ~dm_ack, combinational. Upstream holds all *_Mem inputs stable while it is asserted.
- dm_we = MemWrite_Mem; dm_addr, dm_wdata and dm_be are combinational from the inputs and stable while dm_req=1.
- Store steering:
  - byte: dm_wdata = {4{d[7:0]}}, dm_be = 0001 << addr[1:0].
  - half: dm_wdata = {2{d[15:0]}}, dm_be = addr[1] ? 1100 : 0011.
  - word: dm_be = 1111.
- Load steering:
  - byte: select lane addr[1:0].
  - half: select lane addr[1].
  - Extend to 32 bits with sign or zero per MemSign_Mem.
- WB register, updated every clock edge:
  - if Mem_Stall: inject a bubble (Valid_Wr=0, RegWr_Wr=0, MemToReg_Wr=0, Jal_Wr=0, Rtype_L_Wr=0; data fields unchanged).
  - else: capture all *_Mem fields. Mem_Data_Wr takes the formatted load data when the access completes this cycle, otherwise it holds.
  - RegWr_Wr = RegWr_Mem & Valid_Mem.
- Latency: one cycle Mem→Wr for non-memory instructions; 1+N cycles for an access acked after N wait cycles.
- Without the optional feature, misaligned addresses are handled by ignoring the low bits: half uses addr[1], word uses the full aligned word.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output Misalign_Wr (1 bit, reset 0).
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no bus request and raises no stall.
  - It is captured into the WB register with RegWr_Wr=0 and Misalign_Wr=1 for exactly one cycle.
- Undefined: port absent; silent truncation as in Behaviour.

Decomposition:
- Package mem_wb_pkg holds:
  - MemSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - FSM state encoding (ST_IDLE, ST_WAIT);
  - byte-enable constants.
- One sub-module, load_align: combinational rdata, addr[1:0], size and sign in → 32-bit extended data out. It is instantiated once and unit-tested separately.

Test Plan:
- Zero-wait lw, addr 0x100, dm_ack in the request cycle, dm_rdata 0xDEADBEEF → Mem_Stall never asserted; next cycle Mem_Data_Wr=0xDEADBEEF, RegWr_Wr=1.
- lb signed, addr 0x103, rdata 0x80FF1234, ack after 3 wait cycles → Mem_Stall high for 3 cycles; 3 bubbles with RegWr_Wr=0; then Mem_Data_Wr=0xFFFFFF80. The same case with lbu → 0x00000080.
- sh, addr 0x202, data 0x0000ABCD → dm_wdata=0xABCDABCD, dm_be=1100, dm_we=1, dm_addr=0x200; RegWr_Wr=0.
- jal with PC 0x0040_0010, no memory access → one cycle later PC_Addr_Wr=0x00400010, Jal_Wr=1, dm_req stays 0.
- rst asserted in WAIT → dm_req and all *_Wr drop immediately; a dm_ack arriving after reset release produces no write-back.
- MEM_MISALIGN_TRAP_EN: lw at 0x101 → dm_req=0, Misalign_Wr=1 for one cycle, RegWr_Wr=0.
